// File: rtl/johnson_seq_monitor.sv
// rtl/johnson_seq_monitor.sv - Johnson down-counter sequence monitor
// Decodes 4-bit Johnson codes, tracks stepping order and counts errors and laps.
module johnson_seq_monitor #(
  parameter int ERR_W = 8,
  parameter int LAP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       q_i,
  input  logic             clr_i,
  output logic [2:0]       idx_o,
  output logic             lock_o,
  output logic             illegal_o,
  output logic             seq_err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [LAP_W-1:0] lap_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t     state;
  logic       legal;
  logic [2:0] dec_idx;
  logic [2:0] exp_idx;
  logic       is_exp;
  logic       is_rep;
  logic       err_evt;
  logic       lap_evt;

  always_comb begin
    legal   = 1'b1;
    dec_idx = 3'd0;
    case (q_i)
      4'b1111: dec_idx = 3'd0;
      4'b0111: dec_idx = 3'd1;
      4'b0011: dec_idx = 3'd2;
      4'b0001: dec_idx = 3'd3;
      4'b0000: dec_idx = 3'd4;
      4'b1000: dec_idx = 3'd5;
      4'b1100: dec_idx = 3'd6;
      4'b1110: dec_idx = 3'd7;
      default: legal   = 1'b0;
    endcase
  end

  always_comb begin
    exp_idx = idx_o + 3'd1;
    is_exp  = legal && (dec_idx == exp_idx);
    is_rep  = legal && (dec_idx == idx_o);
    // Out-of-order legal codes only count as errors once we have a reference index.
    err_evt = valid_i && (!legal ||
              ((state == TRACK || state == RESYNC) && !is_exp && !is_rep));
    lap_evt = valid_i && (state == TRACK) && is_exp && (idx_o == 3'd7);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      idx_o     <= 3'd0;
      lock_o    <= 1'b0;
      illegal_o <= 1'b0;
      seq_err_o <= 1'b0;
    end else begin
      illegal_o <= 1'b0;
      seq_err_o <= 1'b0;
      if (valid_i) begin
        case (state)
          IDLE: begin
            if (legal) begin
              idx_o  <= dec_idx;
              state  <= TRACK;
              lock_o <= 1'b1;
            end else begin
              illegal_o <= 1'b1;
              state     <= FAULT;
              lock_o    <= 1'b0;
            end
          end
          TRACK: begin
            if (!legal) begin
              illegal_o <= 1'b1;
              state     <= FAULT;
              lock_o    <= 1'b0;
            end else if (is_exp) begin
              idx_o <= dec_idx;
            end else if (!is_rep) begin
              seq_err_o <= 1'b1;
              idx_o     <= dec_idx;
              state     <= RESYNC;
              lock_o    <= 1'b0;
            end
          end
          RESYNC: begin
            if (!legal) begin
              illegal_o <= 1'b1;
              state     <= FAULT;
            end else if (is_exp) begin
              idx_o  <= dec_idx;
              state  <= TRACK;
              lock_o <= 1'b1;
            end else if (!is_rep) begin
              seq_err_o <= 1'b1;
              idx_o     <= dec_idx;
            end
          end
          FAULT: begin
            if (legal) begin
              idx_o <= dec_idx;
              state <= RESYNC;
            end else begin
              illegal_o <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            lock_o <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt_o <= '0;
      lap_cnt_o <= '0;
    end else if (clr_i) begin
      err_cnt_o <= '0;
      lap_cnt_o <= '0;
    end else begin
      if (err_evt && (err_cnt_o != {ERR_W{1'b1}}))
        err_cnt_o <= err_cnt_o + 1'b1;
      if (lap_evt)
        lap_cnt_o <= lap_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// tb/tb_johnson_seq_monitor.sv - directed bench for johnson_seq_monitor
module tb_johnson_seq_monitor;

  localparam int ERR_W = 2;
  localparam int LAP_W = 8;

  logic             clk_i;
  logic             rst_i;
  logic             valid_i;
  logic [3:0]       q_i;
  logic             clr_i;
  logic [2:0]       idx_o;
  logic             lock_o;
  logic             illegal_o;
  logic             seq_err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [LAP_W-1:0] lap_cnt_o;

  int total;
  int bad;

  logic [3:0] codes [8];

  johnson_seq_monitor #(.ERR_W(ERR_W), .LAP_W(LAP_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .q_i       (q_i),
    .clr_i     (clr_i),
    .idx_o     (idx_o),
    .lock_o    (lock_o),
    .illegal_o (illegal_o),
    .seq_err_o (seq_err_o),
    .err_cnt_o (err_cnt_o),
    .lap_cnt_o (lap_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] q, input logic c);
    @(negedge clk_i);
    valid_i = v;
    q_i     = q;
    clr_i   = c;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  task automatic check_all(input string tag, input int idx, input int lock, input int ill,
                           input int se, input int err, input int lap);
    check({tag, ".idx"},  32'(idx_o),     32'(idx));
    check({tag, ".lock"}, 32'(lock_o),    32'(lock));
    check({tag, ".ill"},  32'(illegal_o), 32'(ill));
    check({tag, ".serr"}, 32'(seq_err_o), 32'(se));
    check({tag, ".err"},  32'(err_cnt_o), 32'(err));
    check({tag, ".lap"},  32'(lap_cnt_o), 32'(lap));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    codes[0] = 4'b1111; codes[1] = 4'b0111; codes[2] = 4'b0011; codes[3] = 4'b0001;
    codes[4] = 4'b0000; codes[5] = 4'b1000; codes[6] = 4'b1100; codes[7] = 4'b1110;
    rst_i   = 1'b0;
    valid_i = 1'b0;
    q_i     = 4'b0000;
    clr_i   = 1'b0;

    // reset state, including a valid strobe while reset is held
    #2;
    check_all("reset", 0, 0, 0, 0, 0, 0);
    valid_i = 1'b1;
    q_i     = 4'b0101;
    @(posedge clk_i);
    #1;
    check_all("reset_hold", 0, 0, 0, 0, 0, 0);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;

    // normal run: 9 samples, one full lap
    for (int i = 0; i < 9; i++) begin
      step(1'b1, codes[i % 8], 1'b0);
      check_all($sformatf("run%0d", i), i % 8, 1, 0, 0, 0, (i == 8) ? 1 : 0);
    end

    // skip from idx 2 to idx 4
    step(1'b1, codes[1], 1'b0);
    step(1'b1, codes[2], 1'b0);
    check_all("skip_pre", 2, 1, 0, 0, 0, 1);
    step(1'b1, 4'b0000, 1'b0);
    check_all("skip", 4, 0, 0, 1, 1, 1);
    step(1'b1, 4'b1000, 1'b0);
    check_all("skip_resync", 5, 1, 0, 0, 1, 1);

    // clear with no sample
    step(1'b0, 4'b0000, 1'b1);
    check_all("clr_idle", 5, 1, 0, 0, 0, 0);

    // illegal codes from TRACK
    step(1'b1, 4'b0101, 1'b0);
    check_all("ill1", 5, 0, 1, 0, 1, 0);
    step(1'b1, 4'b1010, 1'b0);
    check_all("ill2", 5, 0, 1, 0, 2, 0);
    step(1'b1, 4'b1100, 1'b0);
    check_all("ill_resync", 6, 0, 0, 0, 2, 0);
    step(1'b1, 4'b1110, 1'b0);
    check_all("ill_track", 7, 1, 0, 0, 2, 0);

    // stall then repeat
    for (int i = 0; i < 10; i++) begin
      step(1'b0, codes[i % 8], 1'b0);
      check_all($sformatf("stall%0d", i), 7, 1, 0, 0, 2, 0);
    end
    step(1'b1, 4'b1110, 1'b0);
    check_all("repeat", 7, 1, 0, 0, 2, 0);

    // saturation and clear winning over an increment
    step(1'b0, 4'b0000, 1'b1);
    check("sat_clr", 32'(err_cnt_o), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b0101, 1'b0);
      check_all($sformatf("sat%0d", i), 7, 0, 1, 0, (i < 3) ? i + 1 : 3, 0);
    end
    step(1'b1, 4'b1001, 1'b1);
    check_all("clr_win", 7, 0, 1, 0, 0, 0);
    step(1'b0, 4'b1001, 1'b0);
    check_all("pulse_end", 7, 0, 0, 0, 0, 0);

    // FAULT -> RESYNC -> TRACK, then build up 3 laps
    step(1'b1, codes[0], 1'b0);
    check_all("fault_legal", 0, 0, 0, 0, 0, 0);
    step(1'b1, codes[1], 1'b0);
    check_all("relock", 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 23; k++) step(1'b1, codes[(2 + k) % 8], 1'b0);
    check_all("laps", 0, 1, 0, 0, 0, 3);

    // a lap completing together with clr is discarded
    for (int k = 1; k < 8; k++) step(1'b1, codes[k], 1'b0);
    step(1'b1, codes[0], 1'b1);
    check_all("clr_lap", 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 24; k++) step(1'b1, codes[(1 + k) % 8], 1'b0);
    check_all("laps2", 0, 1, 0, 0, 0, 3);

    // async reset between edges
    #2;
    rst_i = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step(1'b1, 4'b0011, 1'b0);
    check_all("post_rst", 2, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
